// File: rtl/add_sub_arbiter_pkg.sv
// Shared types and constants for the add_sub arbiter slice.
// Combinational helpers only; no state lives here.
// Operand coding: bit2 sign, bits1:0 magnitude (sign-magnitude).
package add_sub_arbiter_pkg;

    localparam int OPERAND_W = 3;
    localparam int RESULT_W  = 5;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Sign-magnitude operand to two's complement; 3'b100 (negative zero) maps to 0.
    function automatic logic signed [3:0] sm_to_signed(input logic [OPERAND_W-1:0] sm);
        logic signed [3:0] mag;
        mag = $signed({2'b00, sm[1:0]});
        return sm[2] ? -mag : mag;
    endfunction

endpackage

// File: rtl/add_sub_arbiter_if.sv
// Request/result bundle between operand sources, the arbiter and the consumer.
// Pure wiring, zero latency.
// Request side is valid/ready per requester; result side is a single valid/ready.
interface add_sub_arbiter_if
    import add_sub_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 8
);

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [OPERAND_W*N_REQ-1:0] req_num1;
    logic [OPERAND_W*N_REQ-1:0] req_num2;
    logic [N_REQ-1:0]           req_selection;
    logic                       out_valid;
    logic                       out_ready;
    logic [RESULT_W-1:0]        out_result;
    logic                       out_zeroflag;
    logic [ID_W-1:0]            out_id;
    logic [CNT_W-1:0]           done_count;

    // Operand sources plus result consumer.
    modport master (
        output req_valid, req_num1, req_num2, req_selection, out_ready,
        input  req_ready, out_valid, out_result, out_zeroflag, out_id, done_count
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_num1, req_num2, req_selection, out_ready,
        output req_ready, out_valid, out_result, out_zeroflag, out_id, done_count
    );

endinterface

// File: rtl/add_sub_arbiter_add_sub.sv
// Sign-magnitude adder/subtractor for 3-bit operands, 5-bit sign-magnitude result.
// Purely combinational, zero latency.
// No handshake; the caller holds inputs stable while the result is used.
module add_sub
    import add_sub_arbiter_pkg::*;
(
    input  logic [OPERAND_W-1:0] num1,
    input  logic [OPERAND_W-1:0] num2,
    input  logic                 selection,
    output logic [RESULT_W-1:0]  result,
    output logic                 zeroflag
);

    logic signed [3:0] a_val;
    logic signed [3:0] b_val;
    logic signed [3:0] sum_val;
    logic [3:0]        mag;

    // Result range is -6..+6, so a 4-bit signed intermediate never overflows;
    // a zero sum has a clear sign bit, so negative zero cannot appear.
    always_comb begin
        a_val    = sm_to_signed(num1);
        b_val    = sm_to_signed(num2);
        sum_val  = (selection == SEL_SUB) ? (a_val - b_val) : (a_val + b_val);
        mag      = sum_val[3] ? 4'(-sum_val) : 4'(sum_val);
        result   = {sum_val[3], mag};
        zeroflag = (mag == 4'd0);
    end

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin sharing of one add_sub unit among N_REQ requesters.
// Request accepted at edge N -> out_valid after edge N+1; 3 clocks/op with out_ready high.
// Holds the result in DONE until out_ready; requests are not accepted outside IDLE.
module add_sub_arbiter
    import add_sub_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    add_sub_arbiter_if.slave bus
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [OPERAND_W-1:0]  num1_q, num1_d;
    logic [OPERAND_W-1:0]  num2_q, num2_d;
    logic                  sel_q, sel_d;
    logic [RESULT_W-1:0]   out_result_q, out_result_d;
    logic                  out_zeroflag_q, out_zeroflag_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_W-1:0]      done_count_q, done_count_d;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       cand;
    logic [OPERAND_W-1:0]  grant_num1;
    logic [OPERAND_W-1:0]  grant_num2;
    logic                  grant_sel;
    logic [N_REQ-1:0]      req_ready;
    logic [RESULT_W-1:0]   alu_result;
    logic                  alu_zeroflag;

    // The only arithmetic unit; always fed from the captured operands.
    add_sub u_add_sub (
        .num1      (num1_q),
        .num2      (num2_q),
        .selection (sel_q),
        .result    (alu_result),
        .zeroflag  (alu_zeroflag)
    );

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Mux the granted requester's operand slice out of the packed buses.
    always_comb begin
        grant_num1 = '0;
        grant_num2 = '0;
        grant_sel  = SEL_ADD;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                grant_num1 = bus.req_num1[i*OPERAND_W +: OPERAND_W];
                grant_num2 = bus.req_num2[i*OPERAND_W +: OPERAND_W];
                grant_sel  = bus.req_selection[i];
            end
        end
    end

    // FSM next state, operand capture, result register load and request accept.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        id_d           = id_q;
        num1_d         = num1_q;
        num2_d         = num2_q;
        sel_d          = sel_q;
        out_result_d   = out_result_q;
        out_zeroflag_d = out_zeroflag_q;
        out_id_d       = out_id_q;
        out_valid_d    = out_valid_q;
        done_count_d   = done_count_q;
        req_ready      = '0;

        case (state_q)
            IDLE: begin
                // A granted requester is valid by construction, so ready implies handshake.
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    num1_d       = grant_num1;
                    num2_d       = grant_num2;
                    sel_d        = grant_sel;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                out_result_d   = alu_result;
                out_zeroflag_d = alu_zeroflag;
                out_id_d       = id_q;
                out_valid_d    = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= ID_W'(N_REQ - 1);
            id_q           <= '0;
            num1_q         <= '0;
            num2_q         <= '0;
            sel_q          <= 1'b0;
            out_result_q   <= '0;
            out_zeroflag_q <= 1'b0;
            out_id_q       <= '0;
            out_valid_q    <= 1'b0;
            done_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            id_q           <= id_d;
            num1_q         <= num1_d;
            num2_q         <= num2_d;
            sel_q          <= sel_d;
            out_result_q   <= out_result_d;
            out_zeroflag_q <= out_zeroflag_d;
            out_id_q       <= out_id_d;
            out_valid_q    <= out_valid_d;
            done_count_q   <= done_count_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_zeroflag = out_zeroflag_q;
    assign bus.out_id       = out_id_q;
    assign bus.done_count   = done_count_q;

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
Shares one combinational add_sub unit between N_REQ requesters.
- Each requester presents a 3-bit sign-magnitude operand pair plus an add/sub selection.
- A round-robin arbiter grants one request at a time and the operands are captured.
- The add_sub result is registered and returned with the requester id under a valid/ready handshake.
- The block sits between the operand sources (switch/input logic) and the display/result consumer.

Parameters:
N_REQ, 2, number of requesters (2..4)
ID_W, 1, width of requester id; equals clog2(N_REQ), minimum 1
CNT_W, 8, width of completed-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_num1  in  3*N_REQ  operand 1 per requester, slice i = [3i+2:3i]; bit2 sign, bits1:0 magnitude
req_num2  in  3*N_REQ  operand 2 per requester, same packing
req_selection  in  N_REQ  0 = num1+num2, 1 = num1-num2
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  5  bit4 sign, bits3:0 magnitude
out_zeroflag  out  1  high when magnitude is 0
out_id  out  ID_W  index of requester that issued the operation
done_count  out  CNT_W  completed operations (out handshakes), wraps at 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; all outputs 0, including out_result, out_zeroflag, out_id and done_count.
  - Captured operand registers cleared.
  - Round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: grant = first i with req_valid[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap. req_ready[grant]=1 only in IDLE and only if some req_valid is high; req_ready is combinational from req_valid and state. On the handshake (req_valid[i] & req_ready[i]), capture num1, num2, selection and id; set last_grant=i; go to EXEC. No request: stay in IDLE.
  - EXEC: the add_sub instance is driven from the captured registers. Register its result and zeroflag into out_result/out_zeroflag, out_id = captured id, out_valid=1; go to DONE. req_ready=0.
  - DONE: out_valid=1; all outputs held stable. req_ready=0. On out_ready=1: out_valid=0, done_count+1, go to IDLE. The next request is accepted the following cycle; there is no same-cycle re-accept.
- Latency and throughput:
  - Request handshake at edge N gives out_valid high after edge N+1.
  - With out_ready held high, the cycle is 3 clocks per operation.
- Arithmetic (implemented by add_sub; required for checking):
  - Operand value = (bit2 ? -1 : +1) * bits1:0. Negative zero (3'b100) equals 0.
  - v = num1 ± num2, range -6..+6.
  - out_result = {v<0, |v| in 4 bits}. Zero is always 5'b00000, never negative zero.
  - out_zeroflag = (out_result[3:0]==0).
- Boundary conditions:
  - Requests not granted must be held by their source; the arbiter never drops a valid request.
  - req_valid deasserting while not granted is legal.
  - Request inputs are ignored in EXEC/DONE.
  - Simultaneous requests: exactly one grant; the previously granted requester gets lowest priority next.
  - Single requester: granted every IDLE visit.
  - done_count wraps from 2^CNT_W-1 to 0.
  - rst_n low in any state: immediate return to reset values; an in-flight operation is discarded and produces no out_valid.

Decomposition:
- Shared package:
  - state enum IDLE/EXEC/DONE, encoding 2'b00/2'b01/2'b10.
  - OPERAND_W=3, RESULT_W=5, SEL_ADD=0, SEL_SUB=1.
- Sub-module: the existing add_sub, instantiated once with ports num1, num2, selection, result, zeroflag.
- The round-robin pick is small enough to stay inline; no separate arbiter module.

Test Plan:
- Add, single requester: requester 0 sends num1=3'b011 (+3), num2=3'b110 (-2), selection=0 → out_result=5'b00001, out_zeroflag=0, out_id=0, out_valid rising one edge after the handshake edge.
- Subtract, single requester: requester 1 sends num1=3'b101 (-1), num2=3'b011 (+3), selection=1 → out_result=5'b10100, out_zeroflag=0, out_id=1.
- Negative-zero input: num1=3'b100, num2=3'b000, selection=0 → out_result=5'b00000, out_zeroflag=1.
- Contention: both req_valid held high for 6 operations with out_ready=1 → out_id sequence 0,1,0,1,0,1; done_count=6; never two req_ready bits high.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_result/out_id/out_valid stable, req_ready=0; done_count increments exactly once when out_ready=1.
- Reset mid-operation: rst_n pulsed low during EXEC → out_valid=0, done_count=0 immediately; next grant goes to requester 0.
